param_updown_counter: RTL and testbench
=======================================

// Module: param_updown_counter
// PURPOSE
//  Parametrised up/down counter with programmable modulo, prescaler, load, sync clear,
//  wrap/saturate mode and terminal-count/overflow flags. Successor to the plain 8-bit
//  up-counter: the general event/timebase counter for lab designs (display timebases,
//  event tallies), fed by board clock clk50m.
// PARAMETERS
//  WIDTH     8    counter width in bits, >=2
//  MAX_VAL   255  upper count bound; range 0..MAX_VAL; MAX_VAL <= 2**WIDTH-1, >=1
//  PRESCALE  1    count steps once per PRESCALE enabled cycles; 1 = every enabled cycle
//  SATURATE  0    0 = wrap at bounds, 1 = hold at bounds
// PORTS
//  clk50m    in   1      system clock, rising edge
//  rst       in   1      asynchronous reset, active-high
//  enable    in   1      count enable (qualifies prescaler and steps)
//  dir       in   1      1 = count up, 0 = count down
//  clear     in   1      synchronous clear
//  load      in   1      synchronous load of load_val
//  load_val  in   WIDTH  value to load; clamped to MAX_VAL
//  count     out  WIDTH  current count, registered
//  tc        out  1      terminal-count pulse, registered, 1 cycle per boundary step
//  ovf       out  1      sticky overflow/underflow flag, registered
// BEHAVIOUR
//  - rst=1 (async, any time incl. mid-prescale): count=0, tc=0, ovf=0, prescaler=0.
//  - Priority per edge: rst > clear > load > step. clear/load reset the prescaler.
//  - clear: count<=0, tc<=0, ovf<=0.
//  - load: count<=min(load_val,MAX_VAL), tc<=0, ovf unchanged; enable ignored that cycle.
//  - Prescaler pre: 0..PRESCALE-1, advances only when enable=1; tick = enable &&
//    pre==PRESCALE-1; pre wraps to 0 on tick. enable=0 holds pre (no reset).
//    PRESCALE=1: tick = enable.
//  - step = tick && !clear && !load. Latency: count changes at the step edge.
//  - Up step: count<MAX_VAL -> count+1. count==MAX_VAL -> wrap: 0 / saturate: hold MAX_VAL.
//  - Down step: count>0 -> count-1. count==0 -> wrap: MAX_VAL / saturate: hold 0.
//  - Boundary step (up at MAX_VAL or down at 0): tc<=1 for that edge only, ovf<=1.
//    In saturate mode every step attempted at the bound pulses tc again.
//  - tc=0 on all non-boundary edges. ovf cleared only by rst or clear.
//  - dir changes take effect on the next step; they do not reset the prescaler.
//  - count is never outside 0..MAX_VAL; compare/add in WIDTH+1 bits, no silent wrap
//    at 2**WIDTH when MAX_VAL = 2**WIDTH-1.
// STRUCTURE
//  - Shared package counter_pkg: typedef enum logic {DIR_DOWN=0, DIR_UP=1} dir_t;
//    localparam bit MODE_WRAP=0, MODE_SAT=1.
//  - Sub-module prescaler (PRESCALE param; clk50m, rst, enable, restart -> tick);
//    generate-bypassed when PRESCALE==1.
//  - Top: comb next-state block (count_new, tc_new, ovf_new) + one always_ff register
//    stage with async rst.
// TESTING
//  1. count=0x37 mid-run, assert rst between edges -> count=0, tc=0, ovf=0 immediately.
//  2. MAX_VAL=9, wrap, dir=1, enable 10 cycles from 0 -> 1..9,0; tc=1 only with count=0; ovf=1.
//  3. SATURATE=1, load 2, dir=0, enable 5 cycles -> 1,0,0,0,0; tc pulses on last 3 edges.
//  4. PRESCALE=4, enable 12 cycles -> count steps on edges 4,8,12; enable low 2 cycles
//     after edge 6 -> next step delayed to edge 10.
//  5. MAX_VAL=99: load_val=0xC8 -> count=99; load+clear same edge -> 0; load+enable -> load only.
//  6. WIDTH=8, MAX_VAL=255, wrap: from 255 up -> 0, tc=1; then dir=0 from 0 -> 255, tc=1.

Source files
------------

// File: rtl/counter_pkg.sv
//------------------------------------------------------------------------------
// counter_pkg
// Shared direction and mode encodings for the up/down counter family.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package counter_pkg;
    typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_t;

    localparam bit MODE_WRAP = 1'b0;
    localparam bit MODE_SAT  = 1'b1;
endpackage

`default_nettype wire

// File: rtl/param_updown_counter_prescaler.sv
//------------------------------------------------------------------------------
// prescaler
// Divides enabled cycles by PRESCALE and emits a one-cycle tick; bypassed at 1.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk50m,
    input  logic rst,
    input  logic enable,
    input  logic restart,
    output logic tick
);

    generate
        if (PRESCALE == 1) begin : g_bypass
            logic w_unused;
            assign w_unused = &{1'b0, clk50m, rst, restart};
            assign tick     = enable;
        end else begin : g_div
            localparam int PW = $clog2(PRESCALE);
            localparam logic [PW-1:0] c_last = PW'(PRESCALE - 1);

            logic [PW-1:0] r_pre;
            logic          w_tick;

            assign w_tick = enable && (r_pre == c_last);
            assign tick   = w_tick;

            // Disabled cycles hold the phase; only restart or a tick rewinds it.
            always_ff @(posedge clk50m or posedge rst) begin
                if (rst) begin
                    r_pre <= '0;
                end else if (restart || w_tick) begin
                    r_pre <= '0;
                end else if (enable) begin
                    r_pre <= r_pre + 1'b1;
                end
            end
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/param_updown_counter.sv
//------------------------------------------------------------------------------
// param_updown_counter
// Up/down counter with modulo bound, prescaler, load/clear and tc/ovf flags.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module param_updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MAX_VAL  = 255,
    parameter int PRESCALE = 1,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk50m,
    input  logic             rst,
    input  logic             enable,
    input  logic             dir,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    // Bound compared one bit wider so MAX_VAL = 2**WIDTH-1 cannot alias.
    localparam logic [WIDTH:0]   c_max_ext = (WIDTH + 1)'(MAX_VAL);
    localparam logic [WIDTH-1:0] c_max     = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_ovf;

    logic             w_tick;
    logic             w_step;
    logic [WIDTH-1:0] w_count_new;
    logic             w_tc_new;
    logic             w_ovf_new;

    prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk50m  (clk50m),
        .rst     (rst),
        .enable  (enable),
        .restart (clear | load),
        .tick    (w_tick)
    );

    assign w_step = w_tick && !clear && !load;

    always_comb begin
        w_count_new = r_count;
        w_tc_new    = 1'b0;
        w_ovf_new   = r_ovf;
        if (clear) begin
            w_count_new = '0;
            w_ovf_new   = 1'b0;
        end else if (load) begin
            w_count_new = ({1'b0, load_val} > c_max_ext) ? c_max : load_val;
        end else if (w_step) begin
            if (dir_t'(dir) == DIR_UP) begin
                if ({1'b0, r_count} >= c_max_ext) begin
                    w_tc_new    = 1'b1;
                    w_ovf_new   = 1'b1;
                    w_count_new = (SATURATE == MODE_SAT) ? c_max : '0;
                end else begin
                    w_count_new = r_count + 1'b1;
                end
            end else begin
                if (r_count == '0) begin
                    w_tc_new    = 1'b1;
                    w_ovf_new   = 1'b1;
                    w_count_new = (SATURATE == MODE_SAT) ? '0 : c_max;
                end else begin
                    w_count_new = r_count - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk50m or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_tc    <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_count <= w_count_new;
            r_tc    <= w_tc_new;
            r_ovf   <= w_ovf_new;
        end
    end

    assign count = r_count;
    assign tc    = r_tc;
    assign ovf   = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_param_updown_counter.sv
//------------------------------------------------------------------------------
// tb_param_updown_counter
// Four differently parameterised counters driven in lockstep against a model.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_param_updown_counter;

    logic       clk50m = 1'b0;
    logic       rst, enable, dir, clear, load;
    logic [7:0] load_val;

    logic [7:0] cnt0;  logic tc0, ovf0;
    logic [3:0] cnt1;  logic tc1, ovf1;
    logic [7:0] cnt2;  logic tc2, ovf2;
    logic [5:0] cnt3;  logic tc3, ovf3;

    int n_checks = 0;
    int n_errors = 0;

    // Instance parameters as seen by the model: width, bound, prescale, saturate.
    int c_width[4] = '{8, 4, 8, 6};
    int c_max[4]   = '{255, 9, 99, 40};
    int c_pre[4]   = '{1, 1, 4, 1};
    int c_sat[4]   = '{0, 0, 1, 1};

    int m_cnt[4], m_tc[4], m_ovf[4], m_pre[4];

    always #10 clk50m = ~clk50m;

    param_updown_counter #(.WIDTH(8), .MAX_VAL(255), .PRESCALE(1), .SATURATE(1'b0)) u0 (
        .clk50m(clk50m), .rst(rst), .enable(enable), .dir(dir), .clear(clear), .load(load),
        .load_val(load_val), .count(cnt0), .tc(tc0), .ovf(ovf0));
    param_updown_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(1), .SATURATE(1'b0)) u1 (
        .clk50m(clk50m), .rst(rst), .enable(enable), .dir(dir), .clear(clear), .load(load),
        .load_val(load_val[3:0]), .count(cnt1), .tc(tc1), .ovf(ovf1));
    param_updown_counter #(.WIDTH(8), .MAX_VAL(99), .PRESCALE(4), .SATURATE(1'b1)) u2 (
        .clk50m(clk50m), .rst(rst), .enable(enable), .dir(dir), .clear(clear), .load(load),
        .load_val(load_val), .count(cnt2), .tc(tc2), .ovf(ovf2));
    param_updown_counter #(.WIDTH(6), .MAX_VAL(40), .PRESCALE(1), .SATURATE(1'b1)) u3 (
        .clk50m(clk50m), .rst(rst), .enable(enable), .dir(dir), .clear(clear), .load(load),
        .load_val(load_val[5:0]), .count(cnt3), .tc(tc3), .ovf(ovf3));

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int get_cnt(input int i);
        case (i)
            0: return int'(cnt0);
            1: return int'(cnt1);
            2: return int'(cnt2);
            default: return int'(cnt3);
        endcase
    endfunction

    function automatic int get_tc(input int i);
        case (i)
            0: return int'(tc0);
            1: return int'(tc1);
            2: return int'(tc2);
            default: return int'(tc3);
        endcase
    endfunction

    function automatic int get_ovf(input int i);
        case (i)
            0: return int'(ovf0);
            1: return int'(ovf1);
            2: return int'(ovf2);
            default: return int'(ovf3);
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_cnt[i] = 0; m_tc[i] = 0; m_ovf[i] = 0; m_pre[i] = 0;
        end
    endtask

    // One clock edge of the behavioural rules, evaluated per instance.
    task automatic model_edge();
        int lv;
        bit tick;
        for (int i = 0; i < 4; i++) begin
            m_tc[i] = 0;
            if (rst) begin
                m_cnt[i] = 0; m_ovf[i] = 0; m_pre[i] = 0;
            end else if (clear) begin
                m_cnt[i] = 0; m_ovf[i] = 0; m_pre[i] = 0;
            end else if (load) begin
                lv = int'(load_val) % (1 << c_width[i]);
                m_cnt[i] = (lv > c_max[i]) ? c_max[i] : lv;
                m_pre[i] = 0;
            end else if (enable) begin
                m_pre[i] = m_pre[i] + 1;
                tick = (m_pre[i] == c_pre[i]);
                if (tick) begin
                    m_pre[i] = 0;
                    if (dir && m_cnt[i] == c_max[i]) begin
                        m_tc[i] = 1; m_ovf[i] = 1;
                        m_cnt[i] = c_sat[i] ? c_max[i] : 0;
                    end else if (!dir && m_cnt[i] == 0) begin
                        m_tc[i] = 1; m_ovf[i] = 1;
                        m_cnt[i] = c_sat[i] ? 0 : c_max[i];
                    end else begin
                        m_cnt[i] = dir ? m_cnt[i] + 1 : m_cnt[i] - 1;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("u%0d_count", i), get_cnt(i), m_cnt[i]);
            check($sformatf("u%0d_tc", i), get_tc(i), m_tc[i]);
            check($sformatf("u%0d_ovf", i), get_ovf(i), m_ovf[i]);
        end
    endtask

    task automatic cyc();
        @(posedge clk50m);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic set_in(input bit en, input bit d, input bit clr, input bit ld, input int lv);
        enable = en; dir = d; clear = clr; load = ld; load_val = 8'(lv);
    endtask

    initial begin
        rst = 1'b1;
        set_in(0, 1, 0, 0, 0);
        model_reset();
        #25;
        check_all();
        @(negedge clk50m);
        rst = 1'b0;
        @(posedge clk50m); #1;

        // Modulo-10 wrap from 0 up to 9 and back to 0.
        set_in(1, 1, 0, 0, 0);
        for (int k = 0; k < 10; k++) begin
            cyc();
            check("t2_cnt", int'(cnt1), (k + 1) % 10);
            check("t2_tc", int'(tc1), (k == 9) ? 1 : 0);
        end
        check("t2_ovf", int'(ovf1), 1);

        // Saturating count-down from a loaded 2.
        set_in(0, 0, 0, 1, 2);
        cyc();
        set_in(1, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            cyc();
            check("t3_cnt", int'(cnt3), (k == 0) ? 1 : 0);
            check("t3_tc", int'(tc3), (k >= 2) ? 1 : 0);
        end

        // Prescale-by-4, including a two-cycle enable gap.
        set_in(0, 1, 1, 0, 0);
        cyc();
        set_in(1, 1, 0, 0, 0);
        for (int k = 1; k <= 12; k++) begin
            cyc();
            check("t4_cnt", int'(cnt2), k / 4);
        end
        set_in(0, 1, 1, 0, 0);
        cyc();
        for (int k = 1; k <= 10; k++) begin
            set_in((k == 7 || k == 8) ? 0 : 1, 1, 0, 0, 0);
            cyc();
            check("t4_gap", int'(cnt2), (k >= 10) ? 2 : (k >= 4) ? 1 : 0);
        end

        // Load clamping and priority against clear and enable.
        set_in(0, 1, 0, 1, 8'hC8);
        cyc();
        check("t5_clamp", int'(cnt2), 99);
        set_in(0, 1, 1, 1, 8'hC8);
        cyc();
        check("t5_clr_ld", int'(cnt2), 0);
        set_in(1, 1, 0, 1, 5);
        cyc();
        check("t5_ld_en", int'(cnt2), 5);
        check("t5_ld_en_u0", int'(cnt0), 5);

        // Full-range wrap both ways at 2**WIDTH-1.
        set_in(0, 1, 0, 1, 255);
        cyc();
        set_in(1, 1, 0, 0, 0);
        cyc();
        check("t6_up_cnt", int'(cnt0), 0);
        check("t6_up_tc", int'(tc0), 1);
        set_in(1, 0, 0, 0, 0);
        cyc();
        check("t6_dn_cnt", int'(cnt0), 255);
        check("t6_dn_tc", int'(tc0), 1);

        // Asynchronous reset between edges with a nonzero count and ovf set.
        set_in(0, 1, 0, 1, 8'h37);
        cyc();
        check("t1_pre_cnt", int'(cnt0), 8'h37);
        set_in(0, 1, 0, 0, 0);
        #4;
        rst = 1'b1;
        #1;
        check("t1_rst_cnt", int'(cnt0), 0);
        check("t1_rst_tc", int'(tc0), 0);
        check("t1_rst_ovf", int'(ovf0), 0);
        model_reset();
        check_all();
        @(negedge clk50m);
        rst = 1'b0;
        @(posedge clk50m); #1;

        // Randomised traffic; dir is sticky so the bounds are actually reached.
        dir = 1'b1;
        for (int k = 0; k < 600; k++) begin
            enable   = ($urandom_range(0, 99) < 80);
            if ($urandom_range(0, 99) < 4) dir = ~dir;
            clear    = ($urandom_range(0, 99) < 2);
            load     = ($urandom_range(0, 99) < 4);
            load_val = 8'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b1;
                #3;
                model_reset();
                check_all();
                rst = 1'b0;
            end
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
